// File: rtl/my_pkg.sv
// Shared lcisc types: opcode enum, instruction fields, KISS99 state and the
// program-generator FSM states.
package my_pkg;

   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      MUL = 2'd2,
      DIV = 2'd3
   } opcode_t;

   typedef struct packed {
      opcode_t    opcode;
      logic [7:0] operand1;
      logic [7:0] operand2;
      logic [7:0] dest;
   } inst_t;

   typedef struct packed {
      logic [31:0] z;
      logic [31:0] w;
      logic [31:0] jsr;
      logic [31:0] jcong;
   } kiss99_t;

   localparam logic [31:0] KISS_Z_MUL     = 32'd36969;
   localparam logic [31:0] KISS_W_MUL     = 32'd18000;
   localparam logic [31:0] KISS_JCONG_MUL = 32'd69069;
   localparam logic [31:0] KISS_JCONG_ADD = 32'd1234567;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SEED = 3'd1,
      ST_DRAW = 3'd2,
      ST_EMIT = 3'd3,
      ST_DONE = 3'd4
   } prog_gen_state_t;

endpackage

// File: rtl/lcisc_kiss99_step.sv
// One combinational KISS99 step: advances all four sub-generators and
// forms the 32-bit output from the post-step values.
module lcisc_kiss99_step
   import my_pkg::*;
(
   input  kiss99_t     i_st,
   output kiss99_t     o_st,
   output logic [31:0] o_r
);

   logic [31:0] w_z;
   logic [31:0] w_w;
   logic [31:0] w_j1;
   logic [31:0] w_j2;
   logic [31:0] w_j3;
   logic [31:0] w_jc;

   assign w_z  = (KISS_Z_MUL * {16'd0, i_st.z[15:0]}) + (i_st.z >> 16);
   assign w_w  = (KISS_W_MUL * {16'd0, i_st.w[15:0]}) + (i_st.w >> 16);
   assign w_j1 = i_st.jsr ^ (i_st.jsr << 17);
   assign w_j2 = w_j1 ^ (w_j1 >> 13);
   assign w_j3 = w_j2 ^ (w_j2 << 5);
   assign w_jc = (KISS_JCONG_MUL * i_st.jcong) + KISS_JCONG_ADD;

   assign o_st.z     = w_z;
   assign o_st.w     = w_w;
   assign o_st.jsr   = w_j3;
   assign o_st.jcong = w_jc;
   assign o_r        = (((w_z << 16) + w_w) ^ w_jc) + w_j3;

endmodule

// File: rtl/lcisc_prog_gen.sv
// Pseudo-random lcisc program writer: emits NUM_INST KISS99-derived
// instructions over a valid/ready stream. Optional checksum output is
// enabled by defining LCISC_PROG_GEN_CHECKSUM_EN.
module lcisc_prog_gen
   import my_pkg::*;
#(
   parameter int NUM_INST = 8,
   parameter int NUM_REGS = 16,
   parameter int OP_BITS  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [63:0]     seed,
   output logic            busy,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [7:0]      inst_index,
   output opcode_t         inst_opcode,
   output logic [7:0]      inst_operand1,
   output logic [7:0]      inst_operand2,
   output logic [7:0]      inst_dest,
   output prog_gen_state_t dbg_state,
   output logic            done
`ifdef LCISC_PROG_GEN_CHECKSUM_EN
   ,
   output logic [31:0]     prog_checksum
`endif
);

   localparam logic [7:0]  LAST_INDEX = 8'(NUM_INST - 1);
   localparam logic [31:0] REG_MASK   = 32'(NUM_REGS - 1);

   prog_gen_state_t r_state;
   kiss99_t         r_kiss;
   logic            r_busy;
   logic            r_valid;
   logic            r_done;
   logic [7:0]      r_index;
   inst_t           r_inst;

   kiss99_t         w_kiss_next;
   logic [31:0]     w_r;
   inst_t           w_inst;
   logic            w_start_acc;
   logic            w_hs;

   lcisc_kiss99_step u_step (
      .i_st (r_kiss),
      .o_st (w_kiss_next),
      .o_r  (w_r)
   );

   // Register fields are reduced mod NUM_REGS (a power of two) by masking.
   assign w_inst.opcode   = opcode_t'(OP_BITS'(w_r));
   assign w_inst.operand1 = 8'((w_r >> 8) & REG_MASK);
   assign w_inst.operand2 = 8'((w_r >> 16) & REG_MASK);
   assign w_inst.dest     = 8'((w_r >> 24) & REG_MASK);

   assign w_start_acc = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   // Handshake: an instruction transfers on a rising edge where inst_valid
   // and inst_ready are both high; inst_ready is ignored while inst_valid=0.
   assign w_hs = (r_state == ST_EMIT) && r_valid && inst_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_kiss  <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_index <= 8'd0;
         r_inst  <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (w_start_acc) begin
                  r_kiss.z     <= seed[31:0];
                  r_kiss.w     <= seed[63:32];
                  r_kiss.jsr   <= seed[31:0] ^ seed[63:32];
                  r_kiss.jcong <= seed[63:32];
                  r_done       <= 1'b0;
                  r_busy       <= 1'b1;
                  r_state      <= ST_SEED;
               end
            end
            ST_SEED: begin
               r_index <= 8'd0;
               r_state <= ST_DRAW;
            end
            ST_DRAW: begin
               r_kiss  <= w_kiss_next;
               r_inst  <= w_inst;
               r_valid <= 1'b1;
               r_state <= ST_EMIT;
            end
            ST_EMIT: begin
               if (w_hs) begin
                  r_valid <= 1'b0;
                  if (r_index == LAST_INDEX) begin
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= ST_DONE;
                  end else begin
                     r_index <= r_index + 8'd1;
                     r_state <= ST_DRAW;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef LCISC_PROG_GEN_CHECKSUM_EN
   logic [31:0] r_checksum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_checksum <= 32'd0;
      end else if (w_start_acc) begin
         r_checksum <= 32'd0;
      end else if (w_hs) begin
         r_checksum <= {r_checksum[30:0], r_checksum[31]} ^
                       {r_inst.dest, r_inst.operand2, r_inst.operand1, 8'(r_inst.opcode)};
      end
   end

   assign prog_checksum = r_checksum;
`endif

   assign busy          = r_busy;
   assign inst_valid    = r_valid;
   assign inst_index    = r_index;
   assign inst_opcode   = r_inst.opcode;
   assign inst_operand1 = r_inst.operand1;
   assign inst_operand2 = r_inst.operand2;
   assign inst_dest     = r_inst.dest;
   assign dbg_state     = r_state;
   assign done          = r_done;

endmodule

// File: doc/lcisc_prog_gen.md
Name: lcisc_prog_gen

Overview:
Pseudo-random program writer for the lcisc thread. From a 64-bit seed it generates NUM_INST instructions using the ProgPoW KISS99 generator, and it emits them in order over a valid/ready stream. A loader writes each instruction into thread.code[inst_index]; test_cpu_join later executes those entries. This block is the producer side of the code[] array that the CPU consumes.

Parameters:
NUM_INST, 8, instructions per program (1..256)
NUM_REGS, 16, register count; power of two, at most 16
OP_BITS, 2, opcode select width; 2**OP_BITS equals the number of my_pkg opcodes (ADD, SUB, MUL, DIV)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE or DONE
seed  in  64  program seed; captured on the cycle start is accepted
busy  out  1  high from start acceptance until done
inst_valid  out  1  instruction fields are valid
inst_ready  in  1  consumer accepts when inst_valid and inst_ready are both high
inst_index  out  8  code[] slot, 0..NUM_INST-1
inst_opcode  out  my_pkg opcode type  opcode field
inst_operand1  out  8  source register 1
inst_operand2  out  8  source register 2
inst_dest  out  8  destination register
done  out  1  high in DONE until the next start

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; busy=0, inst_valid=0, done=0, inst_index=0; all instruction fields 0; KISS state 0.
- States: IDLE, SEED, DRAW, EMIT, DONE.
- IDLE or DONE with start=1: capture the seed, set z=seed[31:0], w=seed[63:32], jsr=seed[31:0]^seed[63:32], jcong=seed[63:32]. Clear done, set busy=1, go to SEED.
- SEED: one cycle; inst_index=0; go to DRAW.
- DRAW: one cycle. Step KISS99:
  - z=36969*z[15:0]+(z>>16)
  - w=18000*w[15:0]+(w>>16)
  - jsr^=jsr<<17; jsr^=jsr>>13; jsr^=jsr<<5
  - jcong=69069*jcong+1234567
  - r=(((z<<16)+w)^jcong)+jsr
  - All arithmetic is mod 2^32 and uses the post-step values.
- Register the fields from r, then go to EMIT:
  - opcode=r[OP_BITS-1:0], in my_pkg enum order
  - operand1=r[11:8] mod NUM_REGS
  - operand2=r[19:16] mod NUM_REGS
  - dest=r[27:24] mod NUM_REGS
  - All three register fields are zero-extended to 8 bits.
- EMIT: inst_valid=1. Fields and inst_index stay stable until the handshake.
  - On handshake with inst_index==NUM_INST-1: inst_valid=0 next cycle; go to DONE (done=1, busy=0).
  - On handshake otherwise: inst_index++, then DRAW. inst_valid drops for one cycle, so throughput is one instruction per 2 cycles.
- start while busy is ignored, with no restart.
- seed changes after capture have no effect.
- inst_ready while inst_valid=0 is ignored.
- Reset mid-program: all outputs return to reset values immediately; no partial handshake completes.
- Latency: start accepted at cycle 0 gives the first inst_valid at cycle 3.

Optional Feature:
Macro LCISC_PROG_GEN_CHECKSUM_EN.
- Defined: adds output prog_checksum (32 bits), reset to 0 and cleared on start acceptance. On each handshake it updates as prog_checksum = {prog_checksum[30:0],prog_checksum[31]} ^ {inst_dest,inst_operand2,inst_operand1,8'(inst_opcode)}. The value is valid while done=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- my_pkg additions:
  - kiss99_t struct {z,w,jsr,jcong}, 32 bits each
  - KISS constants 36969, 18000, 69069, 1234567
  - state enum prog_gen_state_t
  - the existing opcode enum and instruction typedef for the fields
- One sub-module, lcisc_kiss99_step: combinational; input kiss99_t, outputs next kiss99_t and 32-bit r. This lets the bench reuse it as a reference model.

Test Plan:
1. Zero seed: seed=0, NUM_INST=4, inst_ready=1. First r=0x0012D687, so the first instruction is opcode=DIV, op1=6, op2=2, dest=0. Exactly 4 handshakes with index 0,1,2,3 (the next three checked against the lcisc_kiss99_step model), then done=1, busy=0.
2. Backpressure: inst_ready=0 for 5 cycles during EMIT. inst_valid stays 1 and the fields stay stable. Raise ready and index advances by exactly 1.
3. Determinism: run seed=64'h0123456789ABCDEF twice. Identical instruction sequences; 4-entry program, and inst_valid rises 3 cycles after start.
4. Start while busy: pulse start mid-program with a different seed. Ignored; sequence continues unchanged; done occurs after NUM_INST handshakes.
5. Reset mid-program: drop rst_n during EMIT at index 2. Outputs go to 0 asynchronously. After release and start with seed=0, the sequence restarts from index 0 and matches test 1.
6. LCISC_PROG_GEN_CHECKSUM_EN: after test 1, prog_checksum equals the model's rotate-XOR over the 4 emitted words. It clears to 0 on the next start.
